// File: rtl/conway_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module   : conway_pattern_loader
// Purpose  : Loads a Game of Life board from a serial stream into a shadow
//            frame. It commits the frame atomically to state_0 and then
//            strobes board_rst. Defining CONWAY_LOADER_PARITY_EN adds a
//            trailing even-parity beat.
// Revision : 1.0
// ============================================================================
module conway_pattern_loader #(
  parameter int N_ROWS = 8,
  parameter int N_COLS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [N_ROWS*N_COLS-1:0]   state_0,
  output logic                       board_rst,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int N_CELLS = N_ROWS * N_COLS;
  localparam int CNT_W   = $clog2(N_CELLS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CELLS - 1);

`ifdef CONWAY_LOADER_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV   = 3'd1,
    PARITY = 3'd2,
    COMMIT = 3'd3,
    APPLY  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV   = 3'd1,
    COMMIT = 3'd3,
    APPLY  = 3'd4
  } state_t;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [N_CELLS-1:0] shadow;
  logic [CNT_W-1:0]   count;
  logic               beat;

  assign beat = s_valid && s_ready;

`ifdef CONWAY_LOADER_PARITY_EN
  logic parity_acc;
  logic parity_ok;
  assign parity_ok = (s_data == parity_acc);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode only the registered state, so s_ready never depends on s_valid.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    board_rst = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RECV;
      end
      RECV: begin
        s_ready = 1'b1;
        if (s_valid && (count == LAST_IDX)) begin
`ifdef CONWAY_LOADER_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = COMMIT;
`endif
        end
      end
`ifdef CONWAY_LOADER_PARITY_EN
      PARITY: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = parity_ok ? COMMIT : IDLE;
      end
`endif
      COMMIT: begin
        state_nxt = APPLY;
      end
      APPLY: begin
        done      = 1'b1;
        board_rst = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The shadow is deliberately not cleared on start: every bit is rewritten by the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      count   <= '0;
      state_0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) count <= '0;
        end
        RECV: begin
          if (beat) begin
            for (int i = 0; i < N_CELLS; i++) begin
              if (count == CNT_W'(i)) shadow[i] <= s_data;
            end
            count <= count + CNT_W'(1);
          end
        end
        COMMIT: begin
          state_0 <= shadow;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CONWAY_LOADER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_acc <= 1'b0;
      error      <= 1'b0;
    end else if ((state == IDLE) && start) begin
      parity_acc <= 1'b0;
      error      <= 1'b0;
    end else if ((state == RECV) && beat) begin
      parity_acc <= parity_acc ^ s_data;
    end else if ((state == PARITY) && beat && !parity_ok) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conway_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_conway_pattern_loader
// Purpose  : Randomised self-checking bench for conway_pattern_loader on a
//            4x4 board. The reference is a whole-frame model: the committed
//            board value and the expected number of load strobes.
// Revision : 1.0
// ============================================================================
module tb_conway_pattern_loader;

  localparam int N_ROWS  = 4;
  localparam int N_COLS  = 4;
  localparam int N_CELLS = N_ROWS * N_COLS;
`ifdef CONWAY_LOADER_PARITY_EN
  localparam int PAR_BEATS = 1;
`else
  localparam int PAR_BEATS = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               s_data;
  logic               s_valid;
  logic               s_ready;
  logic [N_CELLS-1:0] state_0;
  logic               board_rst;
  logic               busy;
  logic               done;
  logic               error;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int brst_seen = 0;
  int exp_loads = 0;
  logic [N_CELLS-1:0] model_state = '0;

  conway_pattern_loader #(.N_ROWS(N_ROWS), .N_COLS(N_COLS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .state_0   (state_0),
    .board_rst (board_rst),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)      done_seen++;
    if (board_rst) brst_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete load attempt. bad_par corrupts the trailing parity beat.
  task automatic run_frame(input logic [N_CELLS-1:0] frame, input bit stalls,
                           input int poke_at, input bit bad_par);
    int k;
    int cyc;
    int total;
    int gap;
    bit mid_checked;
    bit good;
    logic par_bit;
    logic [N_CELLS-1:0] held;
    held        = model_state;
    par_bit     = (^frame) ^ bad_par;
    total       = N_CELLS + PAR_BEATS;
    good        = (PAR_BEATS == 0) || !bad_par;
    mid_checked = 1'b0;

    s_valid = 1'b0;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("error_cleared_by_start", error, 0);

    k   = 0;
    cyc = 0;
    while (k < total && cyc < 4000) begin
      if (stalls) begin
        gap = $urandom_range(0, 5);
        repeat (gap) begin
          s_valid = 1'b0;
          s_data  = 1'($urandom);
          start   = 1'($urandom);
          step();
          cyc++;
        end
      end
      s_valid = 1'b1;
      s_data  = (k < N_CELLS) ? frame[k] : par_bit;
      start   = (k == poke_at);
      if (s_ready) k++;
      step();
      cyc++;
      if (!mid_checked && k == N_CELLS / 2) begin
        check("state0_held_mid_frame", state_0, held);
        mid_checked = 1'b1;
      end
    end
    start = 1'b0;
    if (k < total) check("beat_budget_expired", k, total);

    // Keep offering beats after the frame to probe for overrun.
    s_valid = 1'b1;
    s_data  = 1'($urandom);
    if (good) begin
      check("ready_low_after_frame", s_ready, 0);
      check("no_strobe_in_commit", {board_rst, done}, 2'b00);
      check("state0_held_in_commit", state_0, held);
      step();
      s_data = 1'($urandom);
      check("apply_strobes", {board_rst, done}, 2'b11);
      check("state0_committed", state_0, frame);
      check("ready_low_in_apply", s_ready, 0);
      model_state = frame;
      exp_loads++;
      step();
      s_data = 1'($urandom);
      check("strobes_one_cycle", {board_rst, done}, 2'b00);
      check("idle_after_load", {busy, s_ready}, 2'b00);
      step();
      check("overrun_not_captured", state_0, model_state);
    end else begin
      check("parity_error_set", error, 1);
      check("idle_after_bad_parity", busy, 0);
      check("no_done_bad_parity", {board_rst, done}, 2'b00);
      step();
      check("no_done_bad_parity_late", {board_rst, done}, 2'b00);
      check("state0_kept_bad_parity", state_0, model_state);
      check("error_sticky", error, 1);
    end
    s_valid = 1'b0;
    step();
  endtask

  task automatic mid_frame_reset(input int beats);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < beats; i++) begin
      s_valid = 1'b1;
      s_data  = 1'($urandom);
      step();
    end
    rst     = 1'b1;
    s_valid = 1'b0;
    step();
    rst = 1'b0;
    model_state = '0;
    check("midrst_state0", state_0, 0);
    check("midrst_idle", {busy, s_ready}, 2'b00);
    check("midrst_no_strobe", {board_rst, done}, 2'b00);
    repeat (3) step();
    check("midrst_still_quiet", {busy, board_rst, done}, 3'b000);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_data  = 1'b0;
    s_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("reset_state0", state_0, 0);
    check("reset_ready", s_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_strobes", {board_rst, done}, 2'b00);
    check("reset_error", error, 0);

    // Glider, back to back.
    run_frame(16'h0072, 1'b0, -1, 1'b0);

    // Overwrite with all ones, then abort a new frame with rst.
    run_frame(16'hFFFF, 1'b0, -1, 1'b0);
    mid_frame_reset(9);

    // Glider again with random stalls; state_0 must stay 0 until commit.
    run_frame(16'h0072, 1'b1, -1, 1'b0);

    // Stray start in the middle of a frame.
    run_frame(16'hA5C3, 1'b0, 7, 1'b0);

    for (int n = 0; n < 8; n++) begin
      run_frame(N_CELLS'($urandom), 1'($urandom), int'($urandom_range(0, N_CELLS - 1)), 1'b0);
    end

`ifdef CONWAY_LOADER_PARITY_EN
    run_frame(16'h0072, 1'b0, -1, 1'b0);
    run_frame(16'h0072, 1'b1, -1, 1'b1);
    run_frame(N_CELLS'($urandom), 1'b1, -1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      run_frame(N_CELLS'($urandom), 1'b1, -1, 1'($urandom));
    end
`endif

    check("done_pulse_count", done_seen, exp_loads);
    check("board_rst_pulse_count", brst_seen, exp_loads);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conway_pattern_loader.md
Name: conway_pattern_loader

Overview:
- Loads an initial Game of Life board from a serial bit stream and drives the board's per-cell initial-state bus and board reset.
- Sits upstream of the cell array: it produces the state_0 and reset inputs that each cell consumes.
- Assembles a full frame in a shadow register. Commits it atomically, then pulses the board reset so every cell loads its bit.

Parameters:
- N_ROWS, 8, board rows.
- N_COLS, 8, board columns.
- N_CELLS (local), N_ROWS*N_COLS, frame length in bits. Bit counter width is $clog2(N_CELLS+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame load; sampled only in IDLE.
- s_data  in  1  serial cell bit.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a bit this cycle.
- state_0  out  N_CELLS  committed initial board; bit r*N_COLS+c is cell (r,c).
- board_rst  out  1  reset/load strobe to the cell array.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on a successful load.
- error  out  1  sticky frame error; cleared by the next accepted start or by rst.

Behaviour:
- Reset values: state_0=0, shadow=0, count=0, s_ready=0, board_rst=0, busy=0, done=0, error=0, FSM=IDLE.
- Beat rule: a bit is accepted only when s_valid && s_ready in the same cycle. s_valid may be held or dropped freely; stalls are unbounded.
- s_ready is a registered-state decode: high only in RECV, and in PARITY when the macro is enabled.
- Bit order: the first accepted bit is cell (0,0), row-major. Accepted bit k is written to shadow[k].
- FSM states: IDLE, RECV, PARITY (macro only), COMMIT, APPLY.
- IDLE: when start=1, go to RECV next cycle; count<=0, error<=0. shadow is not cleared; every bit is overwritten during the load.
- RECV: on each beat, shadow[count]<=s_data and count<=count+1. On the beat where count==N_CELLS-1, go to PARITY if the macro is enabled, otherwise COMMIT.
- COMMIT: state_0<=shadow, one cycle, s_ready=0. Go to APPLY.
- APPLY: board_rst=1 and done=1 for exactly this one cycle, with state_0 already stable. Go to IDLE.
- Latency: the last data beat is accepted at edge T. board_rst and done are high in the cycle after edge T+1 (no parity).
- start outside IDLE is ignored, including start in the same cycle as a beat.
- state_0 changes only on the COMMIT edge or on rst. A partial frame never reaches state_0.
- rst mid-frame: returns to IDLE and clears all outputs, including state_0. board_rst is not driven by rst; the top level ORs the system reset in separately.
- No wrap-around: count never exceeds N_CELLS-1 while in RECV. Extra beats after the frame are not accepted because s_ready is low.

Optional Feature:
- Macro: CONWAY_LOADER_PARITY_EN.
- Enabled:
  - After N_CELLS data bits, one further beat is accepted in PARITY; it must equal the XOR of all data bits (even parity).
  - Match: go to COMMIT.
  - Mismatch: error<=1, go to IDLE. There is no COMMIT, state_0 is unchanged, and board_rst and done stay low.
- Disabled: the PARITY state and parity logic are absent. error is tied 0 and a frame is exactly N_CELLS beats.

Test Plan:
1. Reset and basic load (N_ROWS=N_COLS=4, macro off):
   - Stimulus: rst; then start, then 16 back-to-back beats of 0x0072 (bit0 first; glider: bits 1, 4, 5, 6 set).
   - Required: state_0==16'h0072, board_rst=1 and done=1 for one cycle, two cycles after the last beat edge. busy is low afterwards.
2. Stalls:
   - Stimulus: same frame with s_valid toggled randomly and gaps up to 5 cycles.
   - Required: state_0==16'h0072 and exactly 16 beats accepted. state_0 holds its prior value (0) until COMMIT.
3. Ignored start and overrun:
   - Stimulus: pulse start at beat 7; hold s_valid=1 for 3 extra cycles after beat 16.
   - Required: the frame is unaffected, s_ready=0 after beat 16, and the extra bits are not captured.
4. Mid-frame reset:
   - Stimulus: load 16'hFFFF, then start a new frame and assert rst after 9 beats.
   - Required: state_0==0, FSM in IDLE, busy=0, and no done or board_rst pulse.
5. Parity (macro on):
   - Stimulus: frame 16'h0072 (4 ones) with parity bit 0, then the same frame with parity bit 1.
   - Required: the first gives state_0==16'h0072 with a done pulse. The second gives error=1, no done, and state_0 stays 16'h0072. The next start clears error.
